// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment letter codes (abcdefgh order, 1 = lit) and blank pattern
package seg7_pkg;

    typedef enum logic [7:0] {
        A = 8'b1110_1110,
        B = 8'b0011_1110,
        C = 8'b1001_1100,
        D = 8'b0111_1010,
        E = 8'b1001_1110,
        F = 8'b1000_1110,
        G = 8'b1011_1100,
        H = 8'b0110_1110,
        I = 8'b0110_0000,
        J = 8'b0111_0000,
        L = 8'b0001_1100,
        N = 8'b0010_1010,
        O = 8'b1111_1100,
        P = 8'b1100_1110,
        R = 8'b0000_1010,
        S = 8'b1011_0110,
        T = 8'b0001_1110,
        U = 8'b0111_1100,
        Y = 8'b0111_0110
    } seven_seg_encoding_e;

    localparam logic [7:0] SEG7_BLANK = 8'h00;

endpackage

// File: rtl/seg7_msg_buffer.sv
// seg7_msg_buffer: message storage with write pointer, commit/auto-commit, length and sticky overflow
module seg7_msg_buffer #(
    parameter int max_len = 16,
    localparam int len_w = $clog2(max_len + 1),
    localparam int ptr_w = $clog2(max_len)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [7:0]       wr_char,
    input  logic             wr_last,
    input  logic [ptr_w-1:0] rd_idx,
    output logic [7:0]       rd_char,
    output logic             commit,
    output logic [len_w-1:0] len,
    output logic             overflow
);

    logic [7:0]       mem [max_len];
    logic [ptr_w-1:0] wr_ptr;
    logic             at_end;

    assign at_end  = wr_ptr == ptr_w'(max_len - 1);
    assign commit  = wr_valid && (wr_last || at_end);
    assign rd_char = mem[rd_idx];

    always_ff @(posedge clk)
        if (wr_valid) mem[wr_ptr] <= wr_char;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            len      <= '0;
            overflow <= 1'b0;
        end else if (wr_valid) begin
            wr_ptr <= commit ? '0 : wr_ptr + 1'b1;
            if (commit) len <= len_w'(wr_ptr) + 1'b1;
            // a fresh message clears the flag; filling the buffer without an end marker sets it
            overflow <= (at_end && !wr_last) ? 1'b1 : (wr_ptr == '0) ? 1'b0 : overflow;
        end

endmodule

// File: rtl/seg7_scroll_word.sv
// seg7_scroll_word: multiplexed seven-segment word driver with static display or marquee scroll.
// Define SEG7_SCROLL_GAP_EN to insert one blank slot between message repeats while scrolling.
module seg7_scroll_word
    import seg7_pkg::*;
#(
    parameter int w_digit   = 8,
    parameter int max_len   = 16,
    parameter int refresh_w = 17,
    parameter int scroll_w  = 24
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_char,
    input  logic                         wr_last,
    input  logic                         run,
    input  logic                         dir,
    output logic [7:0]                   abcdefgh,
    output logic [w_digit-1:0]           digit,
    output logic [$clog2(max_len+1)-1:0] len,
    output logic                         overflow
);

    localparam int len_w = $clog2(max_len + 1);
    localparam int ptr_w = $clog2(max_len);
    localparam int pos_w = $clog2(w_digit);
    localparam int iw    = len_w + 2;

    logic [refresh_w-1:0] rcnt;
    logic [scroll_w-1:0]  scnt;
    logic [iw-1:0]        offset, cyc_len, idx_raw, idx;
    logic [pos_w-1:0]     pos;
    logic [7:0]           rd_char, pattern;
    logic                 commit, tick, stick, static_mode;

    seg7_msg_buffer #(.max_len(max_len)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_char  (wr_char),
        .wr_last  (wr_last),
        .rd_idx   (ptr_w'(idx)),
        .rd_char  (rd_char),
        .commit   (commit),
        .len      (len),
        .overflow (overflow)
    );

`ifdef SEG7_SCROLL_GAP_EN
    assign cyc_len = iw'(len) + 1'b1;
`else
    assign cyc_len = iw'(len);
`endif

    assign tick        = &rcnt;
    assign stick       = &scnt;
    assign static_mode = len <= len_w'(w_digit);

    // offset < cyc_len and pos < w_digit < cyc_len, so a single subtraction wraps the index
    always_comb begin
        idx_raw = offset + iw'(pos);
        idx     = static_mode ? iw'(pos) : (idx_raw >= cyc_len ? idx_raw - cyc_len : idx_raw);
        pattern = idx >= iw'(len) ? SEG7_BLANK : rd_char;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rcnt     <= '0;
            scnt     <= '0;
            offset   <= '0;
            pos      <= '0;
            abcdefgh <= '0;
            digit    <= '0;
        end else begin
            rcnt <= rcnt + 1'b1;
            scnt <= commit ? '0 : scnt + 1'b1;
            if (commit || static_mode)
                offset <= '0;
            else if (stick && run)
                offset <= dir ? (offset == '0 ? cyc_len - 1'b1 : offset - 1'b1)
                              : (offset + 1'b1 == cyc_len ? '0 : offset + 1'b1);
            if (tick) begin
                abcdefgh <= pattern;
                digit    <= w_digit'(1) << (pos_w'(w_digit - 1) - pos);
                pos      <= pos == pos_w'(w_digit - 1) ? '0 : pos + 1'b1;
            end
        end

endmodule

// File: tb/tb_seg7_scroll_word.sv
// tb_seg7_scroll_word: directed checks of scan order, static display, scrolling, overflow and reset.
module tb_seg7_scroll_word;

    logic       clk = 0, rst = 1, wr_valid = 0, wr_last = 0, run = 0, dir = 0;
    logic [7:0] wr_char = 0, abcdefgh;
    logic [3:0] digit;
    logic [2:0] len;
    logic       overflow;
    int         n_chk = 0, n_fail = 0, cyc = 0, t0;

    seg7_scroll_word #(.w_digit(4), .max_len(6), .refresh_w(2), .scroll_w(5)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char), .wr_last(wr_last),
        .run(run), .dir(dir), .abcdefgh(abcdefgh), .digit(digit), .len(len), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SEG7_SCROLL_GAP_EN
    localparam int cl = 7;
`else
    localparam int cl = 6;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [7:0] c, input logic last);
        wr_valid = 1; wr_char = c; wr_last = last;
        step(1);
        wr_valid = 0; wr_last = 0;
    endtask

    // waits for the next refresh edge that selects digit d
    task automatic wait_dig(input logic [3:0] d);
        logic [3:0] prev;
        logic ok;
        prev = digit; ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1);
            if (digit == d && prev != d) ok = 1;
            prev = digit;
        end
        if (!ok) check("wait_dig", digit, d);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    function automatic logic [7:0] char_at(input int i);
        return i == 6 ? 8'h00 : 8'hC0 + 8'(i);
    endfunction

    initial begin
        #1;
        check("rst_seg", abcdefgh, 0);
        check("rst_digit", digit, 0);
        check("rst_len", len, 0);
        check("rst_ovf", overflow, 0);
        step(2);
        rst = 0;
        step(3);
        check("first_tick_early", digit, 4'b0000);
        step(1);
        check("scan0", digit, 4'b1000);
        for (int i = 1; i <= 4; i++) begin
            step(4);
            check("scan_digit", digit, 4'b1000 >> (i % 4));
            check("scan_blank", abcdefgh, 0);
        end

        run = 1;
        wr(8'h9E, 0);
        wr(8'hBC, 1);
        check("static_len", len, 2);
        wait_dig(4'b1000); check("static_d3", abcdefgh, 8'h9E);
        wait_dig(4'b0100); check("static_d2", abcdefgh, 8'hBC);
        wait_dig(4'b0010); check("static_d1", abcdefgh, 8'h00);
        wait_dig(4'b0001); check("static_d0", abcdefgh, 8'h00);
        step(64);
        wait_dig(4'b1000); check("static_hold", abcdefgh, 8'h9E);

        dir = 0;
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), i == 5);
        t0 = cyc;
        check("scroll_len", len, 6);
        for (int k = 0; k <= cl; k++) begin
            wait_until(t0 + 32 * k + 2);
            wait_dig(4'b1000);
            check("scroll_left", abcdefgh, char_at(k % cl));
        end

        dir = 1;
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), i == 5);
        t0 = cyc;
        for (int k = 0; k <= 4; k++) begin
            if (k == 3) run = 0;
            wait_until(t0 + 32 * k + 2);
            wait_dig(4'b1000);
            check(k < 3 ? "scroll_right" : "run_hold", abcdefgh, char_at((cl - (k < 3 ? k : 2)) % cl));
        end

        dir = 0;
        for (int i = 0; i < 6; i++) wr(8'hD0 + 8'(i), 0);
        check("ovf_len", len, 6);
        check("ovf_set", overflow, 1);
        wr(8'hD6, 0);
        check("ovf_clear", overflow, 0);
        check("ovf_len_keep", len, 6);
        wait_dig(4'b1000); check("ovf_slot0", abcdefgh, 8'hD6);
        wait_dig(4'b0100); check("ovf_slot1", abcdefgh, 8'hD1);

        run = 1;
        step(40);
        rst = 1;
        #1;
        check("async_rst_seg", abcdefgh, 0);
        check("async_rst_digit", digit, 0);
        step(1);
        rst = 0;
        check("post_rst_len", len, 0);
        check("post_rst_ovf", overflow, 0);
        wr(8'hAA, 1);
        check("post_rst_wrptr", len, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
